// File: rtl/exe_stage_md_pkg.sv
// exe_pkg: shared definitions for the execute stage and its multiply/divide unit.
// Holds the 5-bit operation enum (10 ALU ops followed by 8 M-extension ops),
// the mul/div FSM state type, the default datapath width and the is_muldiv()
// helper used to steer ops between the ALU and the iterative unit.
package exe_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // The M ops occupy one contiguous block of the encoding, so a range test suffices.
   function automatic logic is_muldiv(input logic [4:0] op);
      return (op >= 5'(OP_MUL)) && (op <= 5'(OP_REMU));
   endfunction

endpackage

// File: rtl/exe_stage_md_muldiv_iter.sv
// muldiv_iter: iterative multiply / restoring-divide unit for the execute stage.
// Works on operand magnitudes and applies the result sign at the end; divide by
// zero and signed MIN/-1 are resolved at capture time without iterating.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         abort any operation and return to IDLE
//   start_i         capture op_i/a_i/b_i this edge (only a mul/div op)
//   handoff_i       the finished result is being taken by the next stage
//   op_i            operation code (exe_pkg::op_e encoding)
//   a_i, b_i        operands (multiplicand/dividend, multiplier/divisor)
//   done_o          result_o is final (FSM in DONE)
//   busy_o          FSM not IDLE
//   result_o        registered result, stable while DONE
module muldiv_iter
   import exe_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter bit MUL_FAST = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic            handoff_i,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic            busy_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   op_e op_q, op_d;
   logic negQuot_q, negQuot_d;
   logic negRem_q, negRem_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] result_q, result_d;

   op_e opIn;
   logic aSigned, bSigned, aNeg, bNeg;
   logic isMulIn, isRemIn, divZero, divOvf;
   logic [XLEN-1:0] aMag, bMag, specialRes, fastRes;
   logic [2*XLEN-1:0] aExt, bExt, fastProd;

   logic isMulQ;
   logic [2*XLEN-1:0] mulAccNext, prodFix;
   logic [XLEN:0] remShift, remDiff;
   logic quotBit;
   logic [XLEN-1:0] remNext, quotNext, finalRes;

   // Decode the incoming op: which operands are signed, their magnitudes, the
   // early-out special cases and (for MUL_FAST) the full product in one go.
   always_comb begin
      opIn = op_e'(op_i);
      aSigned = 1'b0;
      bSigned = 1'b0;
      case (opIn)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            aSigned = 1'b1;
            bSigned = 1'b1;
         end
         OP_MULHSU: aSigned = 1'b1;
         default: aSigned = 1'b0;
      endcase
      aNeg = aSigned && a_i[XLEN-1];
      bNeg = bSigned && b_i[XLEN-1];
      aMag = aNeg ? -a_i : a_i;
      bMag = bNeg ? -b_i : b_i;
      isMulIn = opIn inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
      isRemIn = opIn inside {OP_REM, OP_REMU};
      divZero = !isMulIn && (b_i == '0);
      divOvf = (opIn inside {OP_DIV, OP_REM}) && (a_i == MIN_VAL) && (b_i == '1);
      specialRes = '0;
      if (divZero) begin
         specialRes = isRemIn ? a_i : '1;
      end else if (divOvf) begin
         specialRes = isRemIn ? '0 : MIN_VAL;
      end
      aExt = aSigned ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
      bExt = bSigned ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
      fastProd = aExt * bExt;
      fastRes = (opIn == OP_MUL) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
   end

   // One iteration of either algorithm plus the sign fix-up applied to the
   // values the last iteration produces. Division keeps the partial remainder in
   // the low half of acc and shifts the dividend out of mplier while the
   // quotient bits shift in behind it.
   always_comb begin
      isMulQ = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
      mulAccNext = acc_q + (mplier_q[0] ? mcand_q : '0);
      remShift = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
      remDiff = remShift - {1'b0, mcand_q[XLEN-1:0]};
      quotBit = ~remDiff[XLEN];
      remNext = quotBit ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
      quotNext = {mplier_q[XLEN-2:0], quotBit};
      prodFix = negQuot_q ? -mulAccNext : mulAccNext;
      case (op_q)
         OP_MUL: finalRes = prodFix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: finalRes = prodFix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU: finalRes = negQuot_q ? -quotNext : quotNext;
         default: finalRes = negRem_q ? -remNext : remNext;
      endcase
   end

   // Next-state logic. A capture can happen from IDLE or on the same edge a
   // DONE result leaves; flush overrides everything and drops back to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      op_d = op_q;
      negQuot_d = negQuot_q;
      negRem_d = negRem_q;
      acc_d = acc_q;
      mcand_d = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      case (state_q)
         MD_IDLE: state_d = MD_IDLE;
         MD_RUN: begin
            if (isMulQ) begin
               acc_d = mulAccNext;
               mcand_d = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end else begin
               acc_d = {{XLEN{1'b0}}, remNext};
               mplier_d = quotNext;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = MD_DONE;
               cnt_d = '0;
               result_d = finalRes;
            end
         end
         MD_DONE: begin
            if (handoff_i) begin
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
      if (start_i && (state_q != MD_RUN)) begin
         op_d = opIn;
         negQuot_d = aNeg ^ bNeg;
         negRem_d = aNeg;
         cnt_d = '0;
         acc_d = '0;
         if (isMulIn) begin
            mcand_d = {{XLEN{1'b0}}, aMag};
            mplier_d = bMag;
            if (MUL_FAST) begin
               state_d = MD_DONE;
               result_d = fastRes;
            end else begin
               state_d = MD_RUN;
            end
         end else begin
            mcand_d = {{XLEN{1'b0}}, bMag};
            mplier_d = aMag;
            if (divZero || divOvf) begin
               state_d = MD_DONE;
               result_d = specialRes;
            end else begin
               state_d = MD_RUN;
            end
         end
      end
      if (flush_i) begin
         state_d = MD_IDLE;
         cnt_d = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q <= '0;
         op_q <= OP_ADD;
         negQuot_q <= 1'b0;
         negRem_q <= 1'b0;
         acc_q <= '0;
         mcand_q <= '0;
         mplier_q <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         op_q <= op_d;
         negQuot_q <= negQuot_d;
         negRem_q <= negRem_d;
         acc_q <= acc_d;
         mcand_q <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
      end
   end

   assign done_o = (state_q == MD_DONE);
   assign busy_o = (state_q != MD_IDLE);
   assign result_o = result_q;

endmodule

// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage between decode and memory. ALU ops finish in one
// cycle; M-extension ops are handed to muldiv_iter and the stage holds them
// until that unit reports done. Provides a forwarding bus with a ready flag so
// decode can stall dependents of an unfinished mul/div.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      kill stage contents, abort mul/div
//   ds_to_es_valid/es_allowin  handshake with decode
//   in_op/in_src1/in_src2      operation and operands
//   in_rd/in_rd_wen/in_pc      destination info and PC, passed through
//   es_to_ms_valid/ms_allowin  handshake with memory stage
//   out_result                 ALU or mul/div result
//   out_rd/out_rd_wen/out_pc   registered pass-through fields
//   fwd_valid/fwd_ready        forwarding: stage writes rd / value is final
//   busy                       mul/div unit not idle
module exe_stage_md
   import exe_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter bit MUL_FAST = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            ds_to_es_valid,
   output logic            es_allowin,
   input  logic [4:0]      in_op,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_src2,
   input  logic [4:0]      in_rd,
   input  logic            in_rd_wen,
   input  logic [XLEN-1:0] in_pc,
   output logic            es_to_ms_valid,
   input  logic            ms_allowin,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_rd_wen,
   output logic [XLEN-1:0] out_pc,
   output logic            fwd_valid,
   output logic            fwd_ready,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   logic esValid_q;
   op_e op_q;
   logic [XLEN-1:0] src1_q, src2_q, pc_q;
   logic [4:0] rd_q;
   logic rdWen_q;

   logic opIsMd, esReadyGo, mdStart, mdHandoff, mdDone;
   logic [SHW-1:0] shamt;
   logic [XLEN-1:0] aluResult, mdResult;

   assign opIsMd = is_muldiv(op_q);
   assign esReadyGo = opIsMd ? mdDone : 1'b1;
   assign es_allowin = !esValid_q || (esReadyGo && ms_allowin);
   assign es_to_ms_valid = esValid_q && esReadyGo;
   assign mdStart = ds_to_es_valid && es_allowin && is_muldiv(in_op) && !flush;
   assign mdHandoff = es_to_ms_valid && ms_allowin;

   // Input register. Flush wins over a capture offered in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         esValid_q <= 1'b0;
         op_q <= OP_ADD;
         src1_q <= '0;
         src2_q <= '0;
         rd_q <= '0;
         rdWen_q <= 1'b0;
         pc_q <= '0;
      end else if (flush) begin
         esValid_q <= 1'b0;
      end else if (es_allowin) begin
         esValid_q <= ds_to_es_valid;
         if (ds_to_es_valid) begin
            op_q <= op_e'(in_op);
            src1_q <= in_src1;
            src2_q <= in_src2;
            rd_q <= in_rd;
            rdWen_q <= in_rd_wen;
            pc_q <= in_pc;
         end
      end
   end

   // Single-cycle ALU on the registered operands; shifts use the low log2(XLEN)
   // bits of src2.
   always_comb begin
      shamt = src2_q[SHW-1:0];
      aluResult = '0;
      case (op_q)
         OP_ADD: aluResult = src1_q + src2_q;
         OP_SUB: aluResult = src1_q - src2_q;
         OP_AND: aluResult = src1_q & src2_q;
         OP_OR: aluResult = src1_q | src2_q;
         OP_XOR: aluResult = src1_q ^ src2_q;
         OP_SLL: aluResult = src1_q << shamt;
         OP_SRL: aluResult = src1_q >> shamt;
         OP_SRA: aluResult = $signed(src1_q) >>> shamt;
         OP_SLT: aluResult = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
         OP_SLTU: aluResult = {{(XLEN-1){1'b0}}, src1_q < src2_q};
         default: aluResult = '0;
      endcase
   end

   muldiv_iter #(
      .XLEN     (XLEN),
      .MUL_FAST (MUL_FAST)
   ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush),
      .start_i   (mdStart),
      .handoff_i (mdHandoff),
      .op_i      (in_op),
      .a_i       (in_src1),
      .b_i       (in_src2),
      .done_o    (mdDone),
      .busy_o    (busy),
      .result_o  (mdResult)
   );

   assign out_result = opIsMd ? mdResult : aluResult;
   assign out_rd = rd_q;
   assign out_rd_wen = rdWen_q;
   assign out_pc = pc_q;
   assign fwd_valid = esValid_q && rdWen_q && (rd_q != 5'd0);
   assign fwd_ready = esReadyGo;

endmodule

// File: tb/tb_exe_stage_md.sv
// Testbench for exe_stage_md. A transaction-level model (expected result from
// plain arithmetic, occupancy as a countdown of cycles) is compared against the
// iterative-multiply instance every cycle; directed ops carry literal results
// and latencies. A second MUL_FAST instance gets literal checks only.
module tb_exe_stage_md;
   import exe_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic dsValid = 1'b0;
   logic [4:0] inOp = 5'd0;
   logic [31:0] inSrc1 = '0, inSrc2 = '0, inPc = '0;
   logic [4:0] inRd = '0;
   logic inRdWen = 1'b0;
   logic msAllowin = 1'b1;
   logic esAllowin, esToMsValid, outRdWen, fwdValid, fwdReady, busy;
   logic [31:0] outResult, outPc;
   logic [4:0] outRd;

   logic fFlush = 1'b0;
   logic fValid = 1'b0;
   logic [4:0] fOp = 5'd0;
   logic [31:0] fSrc1 = '0, fSrc2 = '0, fPc = 32'h2000;
   logic [4:0] fRd = 5'd1;
   logic fRdWen = 1'b1;
   logic fMs = 1'b1;
   logic fAllowin, fOutValid, fOutRdWen, fFwdValid, fFwdReady, fBusy;
   logic [31:0] fResult, fOutPc;
   logic [4:0] fOutRd;

   int testsRun = 0;
   int failCount = 0;
   int seqNo = 1;
   bit cmpEn = 1'b0;

   bit mValid = 1'b0;
   int mRemain = 0;
   int mCap = 0;
   logic [4:0] mOp = '0;
   logic [31:0] mResult = '0, mPc = '0;
   logic [4:0] mRd = '0;
   logic mWen = 1'b0;

   exe_stage_md #(.XLEN(XLEN), .MUL_FAST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ds_to_es_valid(dsValid), .es_allowin(esAllowin),
      .in_op(inOp), .in_src1(inSrc1), .in_src2(inSrc2),
      .in_rd(inRd), .in_rd_wen(inRdWen), .in_pc(inPc),
      .es_to_ms_valid(esToMsValid), .ms_allowin(msAllowin),
      .out_result(outResult), .out_rd(outRd), .out_rd_wen(outRdWen), .out_pc(outPc),
      .fwd_valid(fwdValid), .fwd_ready(fwdReady), .busy(busy)
   );

   exe_stage_md #(.XLEN(XLEN), .MUL_FAST(1'b1)) dutFast (
      .clk(clk), .rst_n(rst_n), .flush(fFlush),
      .ds_to_es_valid(fValid), .es_allowin(fAllowin),
      .in_op(fOp), .in_src1(fSrc1), .in_src2(fSrc2),
      .in_rd(fRd), .in_rd_wen(fRdWen), .in_pc(fPc),
      .es_to_ms_valid(fOutValid), .ms_allowin(fMs),
      .out_result(fResult), .out_rd(fOutRd), .out_rd_wen(fOutRdWen), .out_pc(fOutPc),
      .fwd_valid(fFwdValid), .fwd_ready(fFwdReady), .busy(fBusy)
   );

   always #5 clk = ~clk;

   // Reference result straight from the arithmetic definition of each op.
   function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      int ia, ib;
      sa = $signed(a);
      sb = $signed(b);
      ub = {32'b0, b};
      ia = a;
      ib = b;
      case (op_e'(op))
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         OP_AND: return a & b;
         OP_OR: return a | b;
         OP_XOR: return a ^ b;
         OP_SLL: return a << b[4:0];
         OP_SRL: return a >> b[4:0];
         OP_SRA: return $signed(a) >>> b[4:0];
         OP_SLT: return (ia < ib) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_MUL: begin p = sa * sb; return p[31:0]; end
         OP_MULH: begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         OP_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Edges between capture and the result being final (0 = next cycle).
   function automatic int refLatency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!is_muldiv(op)) return 0;
      if (op >= 5'(OP_DIV)) begin
         if (b == 32'd0) return 0;
         if ((op == 5'(OP_DIV) || op == 5'(OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      end
      return XLEN;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Stage model: one slot, filled on an accepted handshake, drained on handoff.
   always @(posedge clk or negedge rst_n) begin
      bit allow;
      if (!rst_n) begin
         mValid = 1'b0;
         mRemain = 0;
      end else begin
         allow = !mValid || (mRemain == 0 && msAllowin);
         if (flush) begin
            mValid = 1'b0;
         end else if (allow) begin
            mValid = dsValid;
            if (dsValid) begin
               mOp = inOp;
               mResult = refResult(inOp, inSrc1, inSrc2);
               mRemain = refLatency(inOp, inSrc1, inSrc2);
               mRd = inRd;
               mWen = inRdWen;
               mPc = inPc;
               mCap++;
            end
         end else if (mRemain > 0) begin
            mRemain--;
         end
      end
   end

   // Per-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      #1;
      if (rst_n && cmpEn) begin
         checkOutput("es_allowin", esAllowin, !mValid || (mRemain == 0 && msAllowin));
         checkOutput("es_to_ms_valid", esToMsValid, mValid && mRemain == 0);
         checkOutput("fwd_valid", fwdValid, mValid && mWen && mRd != 5'd0);
         checkOutput("busy", busy, mValid && is_muldiv(mOp));
         if (mValid) begin
            checkOutput("out_rd", outRd, mRd);
            checkOutput("out_rd_wen", outRdWen, mWen);
            checkOutput("out_pc", outPc, mPc);
            checkOutput("fwd_ready", fwdReady, mRemain == 0);
            if (mRemain == 0) checkOutput("out_result", outResult, mResult);
         end
      end
   end

   // Offer one op to the main instance; returns at the negedge after capture.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int waited);
      int n0;
      n0 = mCap;
      dsValid = 1'b1;
      inOp = op;
      inSrc1 = a;
      inSrc2 = b;
      inRd = 5'(seqNo % 8);
      inRdWen = (seqNo % 5) != 0;
      inPc = 32'h1000 + 32'(seqNo * 4);
      seqNo++;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (mCap == n0 && waited < 200);
      dsValid = 1'b0;
      checkOutput("capture", mCap != n0, 1);
   endtask

   task automatic runOp(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input int expLat);
      int cycles, w;
      applyStimulus(op, a, b, w);
      cycles = 1;
      while (!esToMsValid && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, "_latency"}, cycles, expLat);
      checkOutput({name, "_result"}, outResult, expRes);
      @(negedge clk);
   endtask

   task automatic runFast(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes, input int expLat);
      int cycles;
      cycles = 0;
      while (!fAllowin && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      fValid = 1'b1;
      fOp = op;
      fSrc1 = a;
      fSrc2 = b;
      @(negedge clk);
      fValid = 1'b0;
      cycles = 1;
      while (!fOutValid && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, "_latency"}, cycles, expLat);
      checkOutput({name, "_result"}, fResult, expRes);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int w, cycles;
      repeat (3) @(negedge clk);
      checkOutput("reset_allowin", esAllowin, 1);
      checkOutput("reset_valid", esToMsValid, 0);
      checkOutput("reset_fwd_valid", fwdValid, 0);
      checkOutput("reset_busy", busy, 0);
      rst_n = 1'b1;
      cmpEn = 1'b1;
      @(negedge clk);

      applyStimulus(5'(OP_ADD), 32'd5, 32'd7, w);
      checkOutput("add_valid", esToMsValid, 1);
      checkOutput("add_result", outResult, 32'd12);
      checkOutput("add_fwd_ready", fwdReady, 1);
      checkOutput("add_fwd_valid", fwdValid, 1);
      @(negedge clk);

      runOp("sub", 5'(OP_SUB), 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
      runOp("sra", 5'(OP_SRA), 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
      runOp("slt", 5'(OP_SLT), 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
      runOp("sltu", 5'(OP_SLTU), 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
      runOp("div", 5'(OP_DIV), 32'd100, 32'd7, 32'd14, 33);
      runOp("rem", 5'(OP_REM), 32'd100, 32'd7, 32'd2, 33);
      runOp("div_neg", 5'(OP_DIV), 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
      runOp("rem_neg", 5'(OP_REM), 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
      runOp("divu_zero", 5'(OP_DIVU), 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
      runOp("remu_zero", 5'(OP_REMU), 32'h1234, 32'd0, 32'h1234, 1);
      runOp("rem_ovf", 5'(OP_REM), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      runOp("div_ovf", 5'(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      runOp("mulh", 5'(OP_MULH), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
      runOp("mulhu", 5'(OP_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      runOp("mulhsu", 5'(OP_MULHSU), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
      runOp("mul", 5'(OP_MUL), 32'h1234_5678, 32'h10, 32'h2345_6780, 33);

      // Result held in DONE while the memory stage stalls.
      msAllowin = 1'b0;
      applyStimulus(5'(OP_DIV), 32'd100, 32'd7, w);
      cycles = 1;
      while (!esToMsValid && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("stall_latency", cycles, 33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_allowin", esAllowin, 0);
         checkOutput("stall_result", outResult, 32'd14);
         checkOutput("stall_valid", esToMsValid, 1);
      end
      msAllowin = 1'b1;
      applyStimulus(5'(OP_ADD), 32'd1, 32'd2, w);
      checkOutput("b2b_capture_edges", w, 1);
      checkOutput("b2b_result", outResult, 32'd3);
      @(negedge clk);

      // Flush during a divide.
      applyStimulus(5'(OP_DIV), 32'd1000, 32'd10, w);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_busy", busy, 0);
      checkOutput("flush_valid", esToMsValid, 0);
      checkOutput("flush_fwd_valid", fwdValid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("flush_no_result", esToMsValid, 0);
      end
      runOp("div_after_flush", 5'(OP_DIV), 32'd1000, 32'd10, 32'd100, 33);

      // Flush beats a capture offered in the same cycle.
      dsValid = 1'b1;
      inOp = 5'(OP_ADD);
      inSrc1 = 32'd9;
      inSrc2 = 32'd9;
      inRd = 5'd4;
      inRdWen = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      dsValid = 1'b0;
      flush = 1'b0;
      checkOutput("flush_capture_valid", esToMsValid, 0);
      checkOutput("flush_capture_fwd", fwdValid, 0);
      @(negedge clk);

      // Reset in the middle of an iterative divide.
      applyStimulus(5'(OP_DIV), 32'd100, 32'd7, w);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", esToMsValid, 0);
      checkOutput("rst_fwd_valid", fwdValid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_allowin", esAllowin, 1);
      checkOutput("rst_out_rd", outRd, 0);
      checkOutput("rst_out_pc", outPc, 0);
      checkOutput("rst_result", outResult, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      runOp("div_after_reset", 5'(OP_DIV), 32'd100, 32'd7, 32'd14, 33);

      // Single-cycle multiplier instance.
      runFast("fast_mul", 5'(OP_MUL), 32'h1234_5678, 32'h10, 32'h2345_6780, 1);
      runFast("fast_mulh", 5'(OP_MULH), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
      runFast("fast_mulhu", 5'(OP_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
      runFast("fast_div", 5'(OP_DIV), 32'd100, 32'd7, 32'd14, 33);

      cmpEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/exe_stage_md.md
# exe_stage_md

Parametrised execute stage with an integrated iterative multiply/divide unit (RV32M/RV64M-style). It sits between decode and memory. It accepts one operation per valid/allowin handshake and completes ALU ops in one cycle. It holds MUL*/DIV*/REM* ops for a multi-cycle shift-add / restoring-divide sequence, exposes a forwarding bus with a data-ready flag, and supports pipeline flush.

## Interface
- XLEN, 32: datapath width (32 or 64).
- MUL_FAST, 0: 1 = single-cycle multiply; 0 = iterative multiply (XLEN iterations).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  kill the stage contents and abort any mul/div in progress.
- ds_to_es_valid  in  1  decode offers an op.
- es_allowin  out  1  stage can accept an op this cycle.
- in_op  in  5  operation code (exe_pkg op enum).
- in_src1, in_src2  in  XLEN  operands.
- in_rd  in  5  destination register.
- in_rd_wen  in  1  destination write enable.
- in_pc  in  XLEN  instruction PC (passed through).
- es_to_ms_valid  out  1  result valid toward memory stage.
- ms_allowin  in  1  memory stage accepts.
- out_result  out  XLEN  ALU or mul/div result.
- out_rd, out_rd_wen, out_pc  out  5/1/XLEN  registered pass-through.
- fwd_valid  out  1  es_valid && rd_wen && rd != 0.
- fwd_ready  out  1  out_result is final (equals es_ready_go).
- busy  out  1  mul/div FSM not IDLE.

## Operation
- Handshake: es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go. The input register loads on ds_to_es_valid && es_allowin; es_valid <= ds_to_es_valid whenever es_allowin.
- ALU ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU): combinational from the registered operands; es_ready_go = 1. Shift amount = src2[log2(XLEN)-1:0].
- Mul/div FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on capture of a mul/div op that is not a special case.
  - IDLE -> DONE on capture of a special case, or of a MUL* op when MUL_FAST = 1.
  - RUN -> DONE after XLEN iterations (counter 0..XLEN-1, one iteration per clock).
  - DONE -> IDLE on a handshake out, or -> RUN/DONE if another mul/div op is captured on the same edge.
- es_ready_go for mul/div ops = (state == DONE).
- MUL returns low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively. The iterative multiplier works on magnitudes with a 2·XLEN-bit accumulator, then applies the sign fix-up.
- DIV/DIVU/REM/REMU use restoring division on magnitudes. The quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign.
- Special cases:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
- Result and FSM state hold stable while DONE and ms_allowin = 0.
- flush has priority over capture. On flush: es_valid <= 0 and state <= IDLE; no result is produced; ops offered in the flush cycle are not captured.
- Reset values: es_valid 0, FSM IDLE, counter 0, all registered fields 0. Consequently es_to_ms_valid, fwd_valid and busy are 0; es_allowin is 1.

## Timing
- Op captured at edge E0.
- ALU op: result and es_to_ms_valid are valid in the cycle after E0 (1 cycle).
- Iterative mul/div: DONE is reached at edge E0+XLEN, so the op occupies the stage for XLEN+1 cycles before es_to_ms_valid.
- Special-case div and fast mul: 1 cycle.
- fwd_valid rises the cycle after capture. fwd_ready stays low until DONE; the decode stage must stall dependents while fwd_valid && !fwd_ready.
- Back-to-back: a new op may be captured on the same edge the previous op hands off.

## Structure
- Package exe_pkg holds:
  - the op enum: 10 ALU ops + 8 M ops, 5 bits;
  - an is_muldiv() helper;
  - the FSM state typedef;
  - the XLEN default.
- Sub-module muldiv_iter owns the FSM, counter, accumulator/remainder registers, sign fix-up and special-case detection. It has a start/flush/done interface.
- The top level contains the ALU, the handshake and the pipeline registers.

## Test plan
- ADD 5+7, ms_allowin = 1 -> out_result 12, es_to_ms_valid the cycle after capture, fwd_ready 1.
- DIV 100/7 (XLEN = 32) -> quotient 14 after 33 cycles in stage. Same operands as REM -> 2. DIV -100/7 -> 0xFFFFFFF2.
- DIVU x/0 -> 0xFFFFFFFF in 1 cycle. REM 0x80000000 / -1 -> 0; DIV of the same operands -> 0x80000000.
- MULH 0xFFFFFFFF×0xFFFFFFFF -> 0. MULHU of the same operands -> 0xFFFFFFFE. MUL 0x12345678×0x10 -> 0x23456780. Repeat with MUL_FAST = 1 and check 1-cycle latency.
- DIV held in DONE with ms_allowin = 0 for 5 cycles -> es_allowin 0, outputs stable. Then raise ms_allowin with a new ADD offered -> handoff and capture on the same edge.
- Flush at iteration 10 of a DIV -> busy 0 and es_valid 0 next cycle, no es_to_ms_valid. The following DIV completes correctly. Reset asserted mid-RUN -> all outputs at reset values.
